seq_alu: RTL

- Parametrised, multi-cycle successor to the CPU datapath ALU.
- Width-generic arithmetic, logic and bit ops; iterative shift-add multiplier; internal flags register.
- valid/ready handshake on both sides so the control unit can stall on long ops.
- Sits between the register-file read ports and the writeback mux.

---
 rtl/seq_alu.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on request and result.
// Single-cycle arithmetic/logic/bit ops, iterative shift-add multiplier and an
// internal {S,V,C,N,Z} flags register (bit0 = Z).
// Optional feature: define SEQ_ALU_DIV_EN to build the restoring divider for
// opcode 15; without it opcode 15 completes in one cycle flagged illegal.
module seq_alu #(
  parameter  int WIDTH = 16,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [IDXW-1:0]  imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [4:0]       flags,
  input  logic             flag_we,
  input  logic [4:0]       flag_wdata,
  output logic             illegal
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR, OP_INV,
    OP_TWC, OP_INC, OP_DEC, OP_SEB, OP_CLB, OP_CMP, OP_MUL, OP_DIV
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);
  localparam int FC = 2;  // carry position inside flags

  state_e state, state_n;
  op_e    op_sel;
  logic   accept;

  // Shared adder serving every add/subtract flavour.
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_v;

  // Single-cycle result path.
  logic [WIDTH-1:0] sc_lo, sc_hi, sc_zn;
  logic             sc_c, sc_v, sc_multi, sc_illegal, sc_upd;
  logic [4:0]       sc_flags;

  // Iterative engine state.
  logic [WIDTH-1:0] opa, acc_hi, acc_lo;
  logic [IDXW-1:0]  cnt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [4:0]       mul_flags, busy_flags;
`ifdef SEQ_ALU_DIV_EN
  logic             busy_div;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
`endif

  assign op_sel    = op_e'(op);
  assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  // Adder operand selection: every arithmetic op is x + y + cin at WIDTH+1 bits.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    add_x   = rs1;
    add_y   = rs2;
    add_cin = 1'b0;
    case (op_sel)
      OP_ADC:         add_cin = flags[FC];
      OP_SUB, OP_CMP: begin add_y = ~rs2; add_cin = 1'b1;      end
      OP_SBC:         begin add_y = ~rs2; add_cin = flags[FC]; end
      OP_TWC:         begin add_x = '0; add_y = ~rs1; add_cin = 1'b1; end
      OP_INC:         begin add_y = '0; add_cin = 1'b1;        end
      OP_DEC:         add_y = '1;
      default:        ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  // Signed overflow: both addends share a sign that the sum does not.
  assign add_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != add_x[WIDTH-1]);

  // Single-cycle result, carry/overflow and routing of multi-cycle ops.
  always_comb begin
    sc_lo      = add_sum[WIDTH-1:0];
    sc_hi      = '0;
    sc_c       = add_sum[WIDTH];
    sc_v       = add_v;
    sc_multi   = 1'b0;
    sc_illegal = 1'b0;
    sc_upd     = 1'b1;
    case (op_sel)
      OP_AND: begin sc_lo = rs1 & rs2; sc_c = 1'b0; sc_v = 1'b0; end
      OP_OR:  begin sc_lo = rs1 | rs2; sc_c = 1'b0; sc_v = 1'b0; end
      OP_XOR: begin sc_lo = rs1 ^ rs2; sc_c = 1'b0; sc_v = 1'b0; end
      OP_INV: begin sc_lo = ~rs1;      sc_c = 1'b0; sc_v = 1'b0; end
      OP_SEB: begin
        sc_lo      = rs1;
        sc_lo[imm] = 1'b1;
        sc_c       = 1'b0;
        sc_v       = 1'b0;
      end
      OP_CLB: begin
        sc_lo      = rs1;
        sc_lo[imm] = 1'b0;
        sc_c       = 1'b0;
        sc_v       = 1'b0;
      end
      OP_CMP: sc_lo = rs1;  // flags from the subtraction, operand passes through
      OP_MUL: sc_multi = 1'b1;
      OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
        if (rs2 == '0) begin
          // Divide by zero resolves immediately with a saturated quotient.
          sc_lo = '1;
          sc_hi = rs1;
          sc_c  = 1'b0;
          sc_v  = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
`else
        sc_lo      = '0;
        sc_c       = 1'b0;
        sc_v       = 1'b0;
        sc_illegal = 1'b1;
        sc_upd     = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // CMP derives Z/N from the difference; everything else from the result.
  assign sc_zn    = (op_sel == OP_CMP) ? add_sum[WIDTH-1:0] : sc_lo;
  assign sc_flags = {sc_zn[WIDTH-1] ^ sc_v, sc_v, sc_c, sc_zn[WIDTH-1], sc_zn == '0};

  // One iteration of the shift-add multiplier (and divider when built).
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opa});
    if (busy_div) begin
      step_hi = div_ge ? div_shift[WIDTH-1:0] - opa : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
`endif
  end

  assign mul_flags = {step_hi[WIDTH-1], 1'b0, step_hi != '0, step_hi[WIDTH-1],
                      {step_hi, step_lo} == '0};
`ifdef SEQ_ALU_DIV_EN
  assign busy_flags = busy_div ?
                      {step_lo[WIDTH-1], 1'b0, 1'b0, step_lo[WIDTH-1], step_lo == '0} :
                      mul_flags;
`else
  assign busy_flags = mul_flags;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic: DONE accepts a new op in the cycle its result is consumed.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)                             state_n = sc_multi ? S_BUSY : S_DONE;
        else if (state == S_DONE && out_ready)  state_n = S_IDLE;
      end
      S_BUSY:  if (cnt == LAST) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result and flags registers.
  // An op's own flag update is written after flag_we so it takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_lo   <= '0;
      res_hi   <= '0;
      flags    <= '0;
      illegal  <= 1'b0;
      opa      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
`ifdef SEQ_ALU_DIV_EN
      busy_div <= 1'b0;
`endif
    end else begin
      if (flag_we) flags <= flag_wdata;
      if (accept) begin
        if (sc_multi) begin
          cnt    <= '0;
          acc_hi <= '0;
`ifdef SEQ_ALU_DIV_EN
          busy_div <= (op_sel == OP_DIV);
          opa      <= (op_sel == OP_DIV) ? rs2 : rs1;
          acc_lo   <= (op_sel == OP_DIV) ? rs1 : rs2;
`else
          opa      <= rs1;
          acc_lo   <= rs2;
`endif
        end else begin
          res_lo  <= sc_lo;
          res_hi  <= sc_hi;
          illegal <= sc_illegal;
          if (sc_upd) flags <= sc_flags;
        end
      end else if (state == S_BUSY) begin
        cnt    <= cnt + 1'b1;
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (cnt == LAST) begin
          res_lo  <= step_lo;
          res_hi  <= step_hi;
          illegal <= 1'b0;
          flags   <= busy_flags;
        end
      end
    end
  end

endmodule
